// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared AXI-Stream constants and helpers
package axis_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int COUNTER_WIDTH   = 32;

  // Number of byte strobes for a given tdata width
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axis_split_counter.sv
// rtl/axis_split_counter.sv - free-running wrap-around event counter with enable
module axis_split_counter
  import axis_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Increment on each enabled cycle; all-ones rolls over to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axis_split.sv
// rtl/axis_split.sv - AXI-Stream broadcast fork with per-packet output mask
module axis_split
  import axis_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = axis_pkg::AXIS_DATA_WIDTH,
  parameter int NUM_OUTPUTS     = 2
) (
  input  logic                                   axis_aclk,
  input  logic                                   axis_aresetn,
  input  logic                                   s_tvalid,
  output logic                                   s_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]             s_tdata,
  input  logic [strb_width(AXIS_DATA_WIDTH)-1:0] s_tstrb,
  input  logic                                   s_tlast,
  input  logic [NUM_OUTPUTS-1:0]                 out_enable,
  output logic [NUM_OUTPUTS-1:0]                 m_tvalid,
  input  logic [NUM_OUTPUTS-1:0]                 m_tready,
  output logic [AXIS_DATA_WIDTH-1:0]             m_tdata,
  output logic [strb_width(AXIS_DATA_WIDTH)-1:0] m_tstrb,
  output logic                                   m_tlast,
  output logic [COUNTER_WIDTH-1:0]               pkt_count,
  output logic [COUNTER_WIDTH-1:0]               drop_count
);

  localparam int STRB_WIDTH = strb_width(AXIS_DATA_WIDTH);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  logic [1:0]             rst_sync;
  logic                   rst_n;
  state_t                 state;
  state_t                 state_next;
  logic [NUM_OUTPUTS-1:0] pending;
  logic [NUM_OUTPUTS-1:0] pkt_mask;
  logic [NUM_OUTPUTS-1:0] beat_mask;
  logic                   accept;
  logic                   pkt_inc;
  logic                   drop_inc;

  // Reset asserts immediately but releases two clocks later, synchronously
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // Upstream may advance only when every output still owing the beat takes it now
  assign s_tready = ~|(pending & ~m_tready);
  assign accept   = s_tvalid & s_tready;
  assign m_tvalid = pending;

  // Packet tracking state register
  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // First beat takes the live enable mask; later beats reuse the latched one
  always_comb begin
    state_next = state;
    beat_mask  = pkt_mask;
    if (state == ST_IDLE) begin
      beat_mask = out_enable;
    end
    if (accept) begin
      state_next = s_tlast ? ST_IDLE : ST_IN_PKT;
    end
  end

  // Shared output register plus per-output outstanding bits
  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      pkt_mask <= '0;
      m_tdata  <= '0;
      m_tstrb  <= '0;
      m_tlast  <= 1'b0;
    end else if (accept) begin
      pending <= beat_mask;
      m_tdata <= s_tdata;
      m_tstrb <= s_tstrb;
      m_tlast <= s_tlast;
      if (state == ST_IDLE) begin
        pkt_mask <= out_enable;
      end
    end else begin
      pending <= pending & ~m_tready;
    end
  end

  // A packet is counted once, on acceptance of its last beat
  assign pkt_inc  = accept & s_tlast & (|beat_mask);
  assign drop_inc = accept & s_tlast & ~(|beat_mask);

  axis_split_counter #(
    .WIDTH (COUNTER_WIDTH)
  ) u_pkt_counter (
    .clk   (axis_aclk),
    .rst_n (rst_n),
    .en    (pkt_inc),
    .count (pkt_count)
  );

  axis_split_counter #(
    .WIDTH (COUNTER_WIDTH)
  ) u_drop_counter (
    .clk   (axis_aclk),
    .rst_n (rst_n),
    .en    (drop_inc),
    .count (drop_count)
  );

  logic unused_strb_width;
  assign unused_strb_width = (STRB_WIDTH == 0);

endmodule

// File: doc/axis_split.md
Name: axis_split

Overview:
- Broadcast fork for AXI4-Stream: one slave stream is fanned out to NUM_OUTPUTS master streams.
- Has a single shared output register stage and independent per-output handshakes.
- Outputs are enabled per packet by a mask that is latched on the first beat of each packet.
- Sits downstream of stream sources in the cosim example master; it is the counterpart of the stream join used on the merge side.

Parameters:
- AXIS_DATA_WIDTH, 32: tdata width in bits; must be a multiple of 8.
- NUM_OUTPUTS, 2: number of master streams, range 1..8.

Ports:
- axis_aclk  in  1  clock; all logic is rising-edge.
- axis_aresetn  in  1  reset, asynchronous, active-low.
- s_tvalid  in  1  slave valid.
- s_tready  out  1  slave ready.
- s_tdata  in  AXIS_DATA_WIDTH  slave data.
- s_tstrb  in  AXIS_DATA_WIDTH/8  slave byte strobes.
- s_tlast  in  1  slave end of packet.
- out_enable  in  NUM_OUTPUTS  per-output enable mask; sampled only on a packet's first beat.
- m_tvalid  out  NUM_OUTPUTS  per-output valid; bit i belongs to output i.
- m_tready  in  NUM_OUTPUTS  per-output ready.
- m_tdata  out  AXIS_DATA_WIDTH  shared data to all outputs.
- m_tstrb  out  AXIS_DATA_WIDTH/8  shared strobes.
- m_tlast  out  1  shared last.
- pkt_count  out  32  count of packets accepted with a nonzero mask.
- drop_count  out  32  count of packets accepted with a zero mask.

Behaviour:
- Reset (asynchronous assert, synchronous deassert internally):
  - m_tvalid=0, m_tdata=0, m_tstrb=0, m_tlast=0.
  - pending=0, pkt_mask=0, in_pkt=0.
  - pkt_count=0, drop_count=0.
  - s_tready is combinational and reads 1 while the buffer is empty.
- State:
  - pending[NUM_OUTPUTS]: outputs still owing acceptance of the registered beat.
  - m_tvalid = pending.
  - in_pkt: 0 = IDLE (next beat is a first beat), 1 = IN_PKT.
- Ready: s_tready = ~|(pending & ~m_tready).
  - Ready is high when every output still owing the beat accepts it this cycle.
  - This gives full throughput of 1 beat per cycle.
  - s_tready is a combinational path from m_tready.
- Accept (s_tvalid & s_tready):
  - The beat's mask is out_enable if in_pkt=0, otherwise pkt_mask.
  - In IDLE, pkt_mask <= out_enable.
  - Data, strobe and last registers load from s_*.
  - pending <= mask.
  - in_pkt <= ~s_tlast.
- No accept: pending <= pending & ~m_tready. Each output clears its bit on its own handshake. Data registers hold.
- Latency: 1 cycle from slave handshake to m_tvalid.
- Per-output independence: a fast output may handshake earlier than a slow one. Its m_tvalid drops after its handshake and stays low until the next beat loads. No beat is ever presented twice to the same output.
- AXIS stability: while pending[i]=1, m_tdata, m_tstrb and m_tlast are constant.
- Zero mask:
  - Beats are accepted (consumed) but produce no m_tvalid.
  - On s_tlast, drop_count increments; otherwise pkt_count increments on s_tlast acceptance.
- Counters wrap 0xFFFF_FFFF -> 0 silently.
- out_enable changes mid-packet are ignored until the next first beat.
- A single-beat packet (tlast on the first beat) latches the mask and returns in_pkt to 0 in the same cycle.
- Reset mid-packet: all in-flight beats are discarded and no partial output completes. A downstream protocol checker must tolerate an abrupt m_tvalid drop at reset.

Decomposition:
- Shared package axis_pkg: AXIS_DATA_WIDTH default, the strobe-width function, and the COUNTER_WIDTH=32 constant.
- No sub-module is needed. An optional axis_split_counter (32-bit saturating-free incrementer with enable) is natural if it is reused for pkt_count and drop_count.

Test Plan:
- Broadcast, both ready, out_enable=2'b11, 4-beat packet 0x11..0x44 with tlast on 0x44 -> each output sees 0x11,0x22,0x33,0x44 on consecutive cycles; s_tready stays 1; pkt_count=1.
- m_tready=2'b01 for 3 cycles, then 2'b11 -> output 0 takes beat 0x11 at cycle 1 and its m_tvalid[0] drops. s_tready is 0 until output 1 accepts. No duplicate beat appears on output 0.
- out_enable=2'b10 on the first beat, switched to 2'b01 on beat 2 of a 3-beat packet -> all 3 beats appear only on output 1; output 0 m_tvalid stays 0.
- out_enable=0, 2-beat packet -> s_tready=1, both m_tvalid stay 0, drop_count=1, pkt_count unchanged.
- Random m_tready (50%) and s_tvalid (70%) over 1000 packets of 1-16 beats -> the scoreboard per output matches the input data/strb/last exactly and pkt_count=1000.
- Assert axis_aresetn low while pending=2'b10 -> m_tvalid=0 immediately (asynchronous). After release, the next beat is treated as a first beat and the mask is re-latched.
